// File: rtl/tt_sweep_checker.sv
// Sweeps every input combination into a combinational truth-table block and checks its output.
// Optional build macro TT_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
//
// state  | meaning
// IDLE   | waiting for start after reset, outputs quiet
// SETTLE | vec driven, settle down-counter running
// SAMPLE | one cycle: compare dut_z against EXPECTED[vec], then advance
// DONE   | sweep finished, results held until start or rst
module tt_sweep_checker #(
    parameter int                    N_IN          = 3,
    parameter logic [(2**N_IN)-1:0]  EXPECTED      = 8'h5A,
    parameter int                    SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_z,
    output logic [N_IN-1:0]   vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_pulse,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err_idx
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     errc_q, errc_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              pulse_q, pulse_d;
    logic              mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            errc_q  <= '0;
            first_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            errc_q  <= errc_d;
            first_q <= first_d;
            pulse_q <= pulse_d;
        end
    end

    // dut_z only matters in SAMPLE; elsewhere the result is discarded.
    assign mismatch = dut_z ^ EXPECTED[vec_q];

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        errc_d  = errc_q;
        first_d = first_q;
        pulse_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    cnt_d   = CNT_RELOAD;
                    errc_d  = '0;
                    first_d = '0;
                end
            end

            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    errc_d  = errc_q + 1'b1;
                    pulse_d = 1'b1;
                    if (errc_q == '0) begin
                        first_d = vec_q;
                    end
                end
`ifdef TT_STOP_ON_ERR_EN
                if (mismatch || (vec_q == VEC_LAST)) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = CNT_RELOAD;
                end
`else
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = CNT_RELOAD;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vec           = vec_q;
    assign busy          = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done          = (state_q == DONE);
    assign pass          = (state_q == DONE) && (errc_q == '0);
    assign err_pulse     = pulse_q;
    assign err_count     = errc_q;
    assign first_err_idx = first_q;

endmodule
